fscmos_ctl: RTL
===============

FSCMOS_CTL -- requirements
Module: fscmos_ctl

Interface
REQ-001 Parameter C_DATA_WIDTH, default 8, pixel data width.
REQ-002 Parameter C_IMG_WBITS, default 12, width of the pixel counter and of cfg_width.
REQ-003 Parameter C_IMG_HBITS, default 12, width of the line counter and of cfg_height.
REQ-004 cmos_pclk  in  1  sole clock; all logic is on its rising edge.
REQ-005 cmos_rst  in  1  reset, asynchronous, active-high.
REQ-006 cmos_vsync  in  1  high during vertical blanking; the frame starts on its falling edge.
REQ-007 cmos_href  in  1  high while a line's pixels are valid.
REQ-008 cmos_data  in  C_DATA_WIDTH  pixel data.
REQ-009 cap_start  in  1  one-cycle request to capture.
REQ-010 cap_stop  in  1  one-cycle request to end capture.
REQ-011 cap_continuous  in  1  sampled with cap_start; 1 = capture frames back-to-back.
REQ-012 cfg_width  in  C_IMG_WBITS  expected pixels per line.
REQ-013 cfg_height  in  C_IMG_HBITS  expected lines per frame.
REQ-014 vid_active_video  out  1  gated pixel valid, registered.
REQ-015 vid_data  out  C_DATA_WIDTH  registered cmos_data.
REQ-016 vid_sof  out  1  high with the first active pixel of a captured frame.
REQ-017 cap_busy  out  1  high in every state except IDLE.
REQ-018 cap_done  out  1  one-cycle pulse per completed frame.
REQ-019 cap_err  out  1  sticky size-mismatch flag.

Function
REQ-020 vsync_d/href_d shall register cmos_vsync/cmos_href by one cycle: frame start = vsync_d & ~cmos_vsync; line end = href_d & ~cmos_href; frame end = ~vsync_d & cmos_vsync.
REQ-021 States: IDLE, WAIT_VS, CAPTURE, DONE.
REQ-022 IDLE -> WAIT_VS on cap_start; cap_continuous latches into cont_q at that edge, and cap_err clears at that edge.
REQ-023 WAIT_VS -> CAPTURE on frame start; capture never begins mid-frame.
REQ-024 CAPTURE -> DONE on frame end.
REQ-025 DONE lasts exactly one cycle with cap_done=1, then -> WAIT_VS if cont_q=1, else -> IDLE.
REQ-026 vid_active_video shall equal (cmos_href & ~cmos_vsync & state==CAPTURE) delayed one cycle, and vid_data shall equal cmos_data delayed one cycle, for a latency of 1.
REQ-027 Outside CAPTURE, vid_active_video=0 and vid_data continues to follow cmos_data.
REQ-028 vid_sof=1 on the first vid_active_video cycle after entering CAPTURE, and 0 at all other times.
REQ-029 px_cnt shall increment on each active pixel in CAPTURE, saturate at all-ones, and clear on line end.
REQ-030 On line end, if px_cnt != cfg_width then cap_err shall be set; line_cnt shall increment, saturating at all-ones.
REQ-031 On frame end, if line_cnt != cfg_height then cap_err shall be set; line_cnt shall clear on frame start.
REQ-032 A line end and a frame end in the same cycle shall perform both checks, and the line shall be counted before the height check.
REQ-033 cap_stop in WAIT_VS -> IDLE next cycle; cap_stop in CAPTURE shall clear cont_q and let the current frame finish through DONE.
REQ-034 cap_stop and cap_start in the same cycle: cap_stop wins, so IDLE stays IDLE.
REQ-035 cap_start outside IDLE shall be ignored.
REQ-036 cfg_width and cfg_height shall be sampled live; changing them mid-frame is undefined.

Reset
REQ-037 While cmos_rst=1: state=IDLE; cont_q, vsync_d, href_d, px_cnt, line_cnt = 0; all outputs 0.
REQ-038 Reset asserted mid-frame shall abort capture immediately; after release, the block waits for cap_start and then a fresh frame start.

Configuration
REQ-039 Macro FSCMOS_CTL_FRMCNT_EN defined: add output frm_cnt [15:0], reset 0, incremented in the cycle after cap_done, wrapping 0xFFFF->0.
REQ-040 Macro FSCMOS_CTL_FRMCNT_EN undefined: frm_cnt port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-041 cfg 4x3, cap_start with cap_continuous=0, one 4x3 frame -> 12 vid_active_video cycles each 1 cycle after the input, vid_sof on the first, one cap_done, cap_err=0, then IDLE.
REQ-042 cap_start while cmos_href is active mid-frame -> no output until the next vsync falling edge; the next full frame is captured.
REQ-043 Frame with one 5-pixel line, cfg_width=4 -> cap_err=1 after that line, held until the next cap_start.
REQ-044 cap_continuous=1, three frames, cap_stop during frame 2 -> cap_done for frames 1 and 2 only; frame 3 produces no active output; ends in IDLE.
REQ-045 cmos_rst pulsed during line 2 of a frame -> all outputs 0 immediately, state IDLE; the remainder of the frame is ignored.
REQ-046 With FSCMOS_CTL_FRMCNT_EN, 3 continuous frames -> frm_cnt=3; preset to 0xFFFF, one frame -> frm_cnt=0.

Source files
------------

// File: rtl/fscmos_ctl.sv
// Frame-synchronous CMOS sensor capture controller: gates the pixel stream to whole frames and checks frame size.
// Latency: vid_active_video / vid_data / vid_sof are registered, 1 cycle behind cmos_href / cmos_data.
// Backpressure: none; the sensor cannot be stalled, so the downstream sink must accept every active pixel.
// Optional: define FSCMOS_CTL_FRMCNT_EN to add the 16-bit completed-frame counter output frm_cnt.
module fscmos_ctl #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_IMG_WBITS  = 12,
  parameter int C_IMG_HBITS  = 12
) (
  input  logic                    cmos_pclk,
  input  logic                    cmos_rst,
  input  logic                    cmos_vsync,
  input  logic                    cmos_href,
  input  logic [C_DATA_WIDTH-1:0] cmos_data,
  input  logic                    cap_start,
  input  logic                    cap_stop,
  input  logic                    cap_continuous,
  input  logic [C_IMG_WBITS-1:0]  cfg_width,
  input  logic [C_IMG_HBITS-1:0]  cfg_height,
  output logic                    vid_active_video,
  output logic [C_DATA_WIDTH-1:0] vid_data,
  output logic                    vid_sof,
  output logic                    cap_busy,
  output logic                    cap_done,
  output logic                    cap_err
`ifdef FSCMOS_CTL_FRMCNT_EN
  ,
  output logic [15:0]             frm_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_cont_q;
  logic                   r_vsync_d;
  logic                   r_href_d;
  logic                   r_sof_pend;
  logic [C_IMG_WBITS-1:0] r_px_cnt;
  logic [C_IMG_HBITS-1:0] r_line_cnt;

  logic                   w_frame_start;
  logic                   w_frame_end;
  logic                   w_line_end;
  logic                   w_in_cap;
  logic                   w_pix_act;
  logic                   w_line_end_cap;
  logic                   w_frame_end_cap;
  logic [C_IMG_HBITS-1:0] w_line_cnt_nxt;
  logic                   w_err_line;
  logic                   w_err_frame;

  // Edges are taken against the previous-cycle copy of the sync inputs.
  assign w_frame_start = r_vsync_d & ~cmos_vsync;
  assign w_frame_end   = ~r_vsync_d & cmos_vsync;
  assign w_line_end    = r_href_d & ~cmos_href;

  assign w_in_cap        = (r_state == S_CAPTURE);
  assign w_pix_act       = cmos_href & ~cmos_vsync & w_in_cap;
  assign w_line_end_cap  = w_line_end & w_in_cap;
  assign w_frame_end_cap = w_frame_end & w_in_cap;

  // A line ending in the same cycle as the frame is counted before the height check.
  assign w_line_cnt_nxt = (w_line_end_cap && (r_line_cnt != '1)) ? r_line_cnt + 1'b1 : r_line_cnt;
  assign w_err_line     = w_line_end_cap & (r_px_cnt != cfg_width);
  assign w_err_frame    = w_frame_end_cap & (w_line_cnt_nxt != cfg_height);

  // Delay the sensor sync lines by one cycle for edge detection.
  always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
    if (cmos_rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= cmos_vsync;
      r_href_d  <= cmos_href;
    end
  end

  // Capture sequencer with registered busy/done/error outputs.
  always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
    if (cmos_rst) begin
      r_state  <= S_IDLE;
      r_cont_q <= 1'b0;
      cap_busy <= 1'b0;
      cap_done <= 1'b0;
      cap_err  <= 1'b0;
    end else begin
      cap_done <= 1'b0;
      if (w_err_line || w_err_frame) begin
        cap_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // Stop beats a simultaneous start.
          if (cap_start && !cap_stop) begin
            r_state  <= S_WAIT_VS;
            r_cont_q <= cap_continuous;
            cap_err  <= 1'b0;
            cap_busy <= 1'b1;
          end
        end
        S_WAIT_VS: begin
          if (cap_stop) begin
            r_state  <= S_IDLE;
            cap_busy <= 1'b0;
          end else if (w_frame_start) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A stop here only cancels continuous mode; the frame in flight completes.
          if (cap_stop) begin
            r_cont_q <= 1'b0;
          end
          if (w_frame_end) begin
            r_state  <= S_DONE;
            cap_done <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_cont_q && !cap_stop) begin
            r_state <= S_WAIT_VS;
          end else begin
            r_state  <= S_IDLE;
            cap_busy <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          cap_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered video stream; data always follows the sensor, valid only while capturing.
  always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
    if (cmos_rst) begin
      vid_active_video <= 1'b0;
      vid_data         <= '0;
      vid_sof          <= 1'b0;
      r_sof_pend       <= 1'b0;
    end else begin
      vid_active_video <= w_pix_act;
      vid_data         <= cmos_data;
      vid_sof          <= w_pix_act & r_sof_pend;
      // Re-armed whenever not capturing, consumed by the first active pixel of the frame.
      if (!w_in_cap) begin
        r_sof_pend <= 1'b1;
      end else if (w_pix_act) begin
        r_sof_pend <= 1'b0;
      end
    end
  end

  // Pixel and line counters feeding the frame-size checks.
  always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
    if (cmos_rst) begin
      r_px_cnt   <= '0;
      r_line_cnt <= '0;
    end else begin
      if (w_frame_start || w_line_end) begin
        r_px_cnt <= '0;
      end else if (w_pix_act && (r_px_cnt != '1)) begin
        r_px_cnt <= r_px_cnt + 1'b1;
      end
      if (w_frame_start) begin
        r_line_cnt <= '0;
      end else begin
        r_line_cnt <= w_line_cnt_nxt;
      end
    end
  end

`ifdef FSCMOS_CTL_FRMCNT_EN
  // Completed-frame counter, wraps at 16 bits; visible the cycle after cap_done.
  always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
    if (cmos_rst) begin
      frm_cnt <= 16'd0;
    end else if (cap_done) begin
      frm_cnt <= frm_cnt + 16'd1;
    end
  end
`endif

endmodule
